// File: rtl/alarma_ctrl.sv
// alarma_ctrl: three-sensor alarm sequencer.
//   Synchronises {a,b,c}, evaluates the trigger from a truth-table mask,
//   debounces it and runs IDLE -> EXIT -> ARMED -> ENTRY -> ALARM.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   a, b, c           raw sensor inputs
//   arm, disarm       keypad level requests, sampled every edge
//   state[2:0]        0 IDLE, 1 EXIT, 2 ARMED, 3 ENTRY, 4 ALARM
//   armed             1 in ARMED, ENTRY or ALARM
//   siren             1 only in ALARM
//   alarm_cnt[3:0]    alarms since reset, saturating at 15
module alarma_ctrl #(
  parameter logic [7:0]  TRIG_MASK = 8'b1110_1000,
  parameter int unsigned EXIT_CYC  = 16,
  parameter int unsigned ENTRY_CYC = 8,
  parameter int unsigned ALARM_CYC = 32,
  parameter int unsigned DEB_CYC   = 2,
  parameter int unsigned TW        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       arm,
  input  logic       disarm,
  output logic [2:0] state,
  output logic       armed,
  output logic       siren,
  output logic [3:0] alarm_cnt
);

  localparam int unsigned DW = (DEB_CYC < 1) ? 1 : $clog2(DEB_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EXIT  = 3'd1,
    S_ARMED = 3'd2,
    S_ENTRY = 3'd3,
    S_ALARM = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [2:0]    s_reg_q, s_reg_d;
  logic [3:0]    alarm_cnt_q, alarm_cnt_d;
  logic          armed_q, armed_d;
  logic          siren_q, siren_d;
  logic          trig;
  logic          trig_ok;

  // Sensor sampling and debounce.
  always_comb begin
    s_reg_d = {a, b, c};
    trig    = TRIG_MASK[s_reg_q];
    trig_ok = (deb_cnt_q == DW'(DEB_CYC));
    if (!trig) begin
      deb_cnt_d = '0;
    end else if (trig_ok) begin
      deb_cnt_d = deb_cnt_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end
  end

  // Next state, timer and output decode.
  always_comb begin
    state_d     = state_q;
    timer_d     = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
    alarm_cnt_d = alarm_cnt_q;

    case (state_q)
      S_IDLE: begin
        // disarm wins over arm, which here means staying idle
        if (arm && !disarm) begin
          state_d = S_EXIT;
          timer_d = TW'(EXIT_CYC - 1);
        end
      end
      S_EXIT: begin
        if (disarm) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (disarm) begin
          state_d = S_IDLE;
        end else if (trig_ok) begin
          state_d = S_ENTRY;
          timer_d = TW'(ENTRY_CYC - 1);
        end
      end
      S_ENTRY: begin
        if (disarm) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_ALARM;
          timer_d = TW'(ALARM_CYC - 1);
          if (alarm_cnt_q != 4'hF) begin
            alarm_cnt_d = alarm_cnt_q + 4'd1;
          end
        end
      end
      S_ALARM: begin
        if (disarm) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_ARMED;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Decoded from the next state so they move on the same edge as state.
    armed_d = (state_d == S_ARMED) || (state_d == S_ENTRY) || (state_d == S_ALARM);
    siren_d = (state_d == S_ALARM);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      deb_cnt_q   <= '0;
      s_reg_q     <= '0;
      alarm_cnt_q <= '0;
      armed_q     <= 1'b0;
      siren_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      deb_cnt_q   <= deb_cnt_d;
      s_reg_q     <= s_reg_d;
      alarm_cnt_q <= alarm_cnt_d;
      armed_q     <= armed_d;
      siren_q     <= siren_d;
    end
  end

  assign state     = state_q;
  assign armed     = armed_q;
  assign siren     = siren_q;
  assign alarm_cnt = alarm_cnt_q;

endmodule
